// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and constants for the register-bank arbiter.
//   arb_state_t : arbiter FSM states
//   ARB_RR      : round-robin arbitration mode
//   ARB_FIXED   : fixed-priority arbitration mode (host 0 highest)
//   idx_w()     : width of a host index, at least one bit
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   localparam int unsigned ARB_RR    = 0;
   localparam int unsigned ARB_FIXED = 1;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_picker.sv
// rr_picker: combinational masked priority select.
//   pending : request bits, one per host
//   ptr     : round-robin start index (ignored in fixed-priority mode)
//   valid   : at least one pending bit is set
//   index   : selected host; first pending at or after ptr (wrapping),
//             or lowest pending index in fixed-priority mode
module rr_picker
   import reg_arb_pkg::*;
#(
   parameter int unsigned N    = 2,
   parameter int unsigned MODE = ARB_RR
) (
   input  logic [N-1:0]           pending,
   input  logic [idx_w(N)-1:0]    ptr,
   output logic                   valid,
   output logic [idx_w(N)-1:0]    index
);

   localparam int unsigned W = idx_w(N);

   always_comb begin
      int unsigned start;
      int unsigned idx;
      valid = 1'b0;
      index = '0;
      start = (MODE == ARB_FIXED) ? 32'd0 : 32'(ptr);
      idx   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (start + k) % N;
         if (!valid && pending[idx]) begin
            valid = 1'b1;
            index = W'(idx);
         end
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: N-host arbiter in front of reg_bank (host 0 = SPI, host 1 = I2C).
//   clk, rstb         : clock, asynchronous active-low reset
//   ena               : low blocks new grants; in-flight access completes
//   host_req          : 1-cycle request strobe per host, queued as pending bits
//   host_wr_rdn/addr/wdata : per-host access fields, packed, held by host until done
//   host_done/err     : 1-cycle completion pulse (and error flag) to issuing host
//   host_rdata        : broadcast read data, valid with host_done
//   bank_we/re        : 1-cycle strobes to the bank
//   bank_addr/wdata   : registered, held for the access and in IDLE
//   bank_rdata/ack/err: bank response, looked at only in WAIT
//   ovf_clr, ovf      : sticky overflow (req while already pending), set wins over clear
//   busy, grant       : FSM not IDLE, index of host being served
module reg_bank_arbiter
   import reg_arb_pkg::*;
#(
   parameter int unsigned N_HOSTS  = 2,
   parameter int unsigned REG_W    = 8,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned ARB_MODE = ARB_RR,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic                        clk,
   input  logic                        rstb,
   input  logic                        ena,
   input  logic [N_HOSTS-1:0]          host_req,
   input  logic [N_HOSTS-1:0]          host_wr_rdn,
   input  logic [N_HOSTS*ADDR_W-1:0]   host_addr,
   input  logic [N_HOSTS*REG_W-1:0]    host_wdata,
   output logic [N_HOSTS-1:0]          host_done,
   output logic [N_HOSTS-1:0]          host_err,
   output logic [REG_W-1:0]            host_rdata,
   output logic                        bank_we,
   output logic                        bank_re,
   output logic [ADDR_W-1:0]           bank_addr,
   output logic [REG_W-1:0]            bank_wdata,
   input  logic [REG_W-1:0]            bank_rdata,
   input  logic                        bank_ack,
   input  logic                        bank_err,
   input  logic                        ovf_clr,
   output logic [N_HOSTS-1:0]          ovf,
   output logic                        busy,
   output logic [idx_w(N_HOSTS)-1:0]   grant
);

   localparam int unsigned GW = idx_w(N_HOSTS);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   arb_state_t         state, state_nxt;
   logic [N_HOSTS-1:0] pending;
   logic [N_HOSTS-1:0] resp_sel;
   logic [N_HOSTS-1:0] req_dup;
   logic [N_HOSTS-1:0] req_acc;
   logic [N_HOSTS-1:0] pick_pend;
   logic [GW-1:0]      rr_ptr;
   logic               pick_valid;
   logic [GW-1:0]      pick_index;
   logic               wr_q;
   logic               err_q;
   logic [CW-1:0]      wait_cnt;
   logic               take;
   logic               timed_out;

   // A host finishing in RESP frees its slot this cycle, so a new req from it is
   // accepted rather than counted as an overflow.
   assign resp_sel  = (state == RESP) ? (N_HOSTS'(1) << grant) : '0;
   assign req_dup   = host_req & pending & ~resp_sel;
   assign req_acc   = host_req & ~req_dup;
   // Same-cycle requests can win the grant directly from IDLE.
   assign pick_pend = pending | req_acc;
   assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));

   rr_picker #(
      .N    (N_HOSTS),
      .MODE (ARB_MODE)
   ) u_picker (
      .pending (pick_pend),
      .ptr     (rr_ptr),
      .valid   (pick_valid),
      .index   (pick_index)
   );

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      unique case (state)
         IDLE: begin
            if (ena && pick_valid) begin
               take      = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (bank_ack || bank_err || timed_out) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state      <= IDLE;
         pending    <= '0;
         ovf        <= '0;
         rr_ptr     <= '0;
         grant      <= '0;
         wr_q       <= 1'b0;
         err_q      <= 1'b0;
         wait_cnt   <= '0;
         bank_we    <= 1'b0;
         bank_re    <= 1'b0;
         bank_addr  <= '0;
         bank_wdata <= '0;
         host_rdata <= '0;
      end else begin
         state   <= state_nxt;
         pending <= (pending & ~resp_sel) | req_acc;
         ovf     <= (ovf & ~{N_HOSTS{ovf_clr}}) | req_dup;
         bank_we <= 1'b0;
         bank_re <= 1'b0;

         if (take) begin
            grant      <= pick_index;
            wr_q       <= host_wr_rdn[pick_index];
            bank_addr  <= host_addr[32'(pick_index)*ADDR_W +: ADDR_W];
            bank_wdata <= host_wdata[32'(pick_index)*REG_W +: REG_W];
         end

         if (state == ISSUE) begin
            bank_we  <= wr_q;
            bank_re  <= ~wr_q;
            wait_cnt <= '0;
         end

         if (state == WAIT) begin
            wait_cnt <= wait_cnt + CW'(1);
            if (bank_err) begin
               err_q <= 1'b1;
            end else if (bank_ack) begin
               err_q <= 1'b0;
               if (!wr_q) host_rdata <= bank_rdata;
            end else if (timed_out) begin
               err_q <= 1'b1;
            end
         end

         if (state == RESP) begin
            rr_ptr <= (grant == GW'(N_HOSTS - 1)) ? '0 : grant + GW'(1);
         end
      end
   end

   assign host_done = resp_sel;
   assign host_err  = err_q ? resp_sel : '0;
   assign busy      = (state != IDLE);

endmodule
